// File: rtl/voc_pkg.sv
// Shared types and helpers for the VOC decision sequencer and its stability filter.
package voc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int CLASS_NONE = 0;
    localparam int RUN_CNT_W  = 4;

    // Smallest class width that can encode "none" plus one code per channel.
    function automatic int class_w_for(input int n_ch);
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) > n_ch) return w;
        end
        return 32;
    endfunction

endpackage

// File: rtl/class_stability_filter.sv
// Commits a class only after STABLE_CNT consecutive identical raw results;
// pulses changed when the committed class takes a new value.
module class_stability_filter #(
    parameter int CLASS_W    = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               update,
    input  logic [CLASS_W-1:0] raw_in,
    output logic [CLASS_W-1:0] raw_class,
    output logic [CLASS_W-1:0] class_out,
    output logic               changed
);
    import voc_pkg::*;

    localparam logic [RUN_CNT_W-1:0] CNT_MAX = RUN_CNT_W'(STABLE_CNT);

    logic [CLASS_W-1:0]   raw_q, raw_d;
    logic [CLASS_W-1:0]   cls_q, cls_d;
    logic [RUN_CNT_W-1:0] cnt_q, cnt_d;
    logic                 chg_q, chg_d;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latches).
    always_comb begin
        raw_d = raw_q;
        cls_d = cls_q;
        cnt_d = cnt_q;
        chg_d = 1'b0;
        if (update) begin
            raw_d = raw_in;
            if (raw_in != raw_q) begin
                cnt_d = RUN_CNT_W'(1);
            end else if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + RUN_CNT_W'(1);
            end
            // Saturated counter plus the inequality test keeps a held class from re-pulsing.
            if (cnt_d == CNT_MAX && raw_in != cls_q) begin
                cls_d = raw_in;
                chg_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q <= CLASS_W'(CLASS_NONE);
            cls_q <= CLASS_W'(CLASS_NONE);
            cnt_q <= '0;
            chg_q <= 1'b0;
        end else begin
            raw_q <= raw_d;
            cls_q <= cls_d;
            cnt_q <= cnt_d;
            chg_q <= chg_d;
        end
    end

    assign raw_class = raw_q;
    assign class_out = cls_q;
    assign changed   = chg_q;

endmodule

// File: rtl/voc_decision_seq.sv
// Sequential argmax-above-threshold classifier over N_CH sensor channels,
// with start/busy/valid handshake and a stability-filtered committed class.
module voc_decision_seq #(
    parameter int N_CH       = 5,
    parameter int DATA_W     = 32,
    parameter int CLASS_W    = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DATA_W-1:0]        threshold,
    input  logic [N_CH*DATA_W-1:0]   chan_data,
    output logic                     busy,
    output logic                     valid,
    output logic [CLASS_W-1:0]       raw_class,
    output logic [CLASS_W-1:0]       class_out,
    output logic                     changed
);
    import voc_pkg::*;

    if (CLASS_W < class_w_for(N_CH) || N_CH < 2 || N_CH > 15 ||
        STABLE_CNT < 1 || STABLE_CNT > 15) begin : g_bad_params
        $error("voc_decision_seq: illegal parameter combination");
    end

    localparam logic [CLASS_W-1:0] LAST_CH = CLASS_W'(N_CH - 1);

    state_e                   state_q, state_d;
    logic [CLASS_W-1:0]       ch_q, ch_d;
    logic [CLASS_W-1:0]       best_idx_q, best_idx_d;
    logic [DATA_W-1:0]        best_val_q, best_val_d;
    logic [DATA_W-1:0]        thr_q, thr_d;
    logic [N_CH*DATA_W-1:0]   data_q, data_d;
    logic                     busy_q, valid_q;
    logic [DATA_W-1:0]        sample;
    logic                     cand;
    logic                     scan_last;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        thr_d      = thr_q;
        data_d     = data_q;

        sample    = data_q[int'(ch_q) * DATA_W +: DATA_W];
        // Strict greater-than lets the lowest channel win among equal maxima.
        cand      = (sample >= thr_q) &&
                    (best_idx_q == CLASS_W'(CLASS_NONE) || sample > best_val_q);
        scan_last = (state_q == ST_SCAN) && (ch_q == LAST_CH);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d     = chan_data;
                    thr_d      = threshold;
                    best_idx_d = CLASS_W'(CLASS_NONE);
                    best_val_d = '0;
                    ch_d       = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cand) begin
                    best_idx_d = ch_q + CLASS_W'(1);
                    best_val_d = sample;
                end
                if (ch_q == LAST_CH) begin
                    state_d = ST_DONE;
                end else begin
                    ch_d = ch_q + CLASS_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            thr_q      <= '0;
            // NOTE: the wide capture register is reset explicitly so no stale samples survive a reset.
            data_q     <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            thr_q      <= thr_d;
            data_q     <= data_d;
            busy_q     <= (state_d != ST_IDLE);
            valid_q    <= (state_d == ST_DONE);
        end
    end

    // Filter loads on the edge entering DONE so its outputs line up with valid.
    class_stability_filter #(
        .CLASS_W    (CLASS_W),
        .STABLE_CNT (STABLE_CNT)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .update    (scan_last),
        .raw_in    (best_idx_d),
        .raw_class (raw_class),
        .class_out (class_out),
        .changed   (changed)
    );

    assign busy  = busy_q;
    assign valid = valid_q;

endmodule

// File: doc/voc_decision_seq.md
Name: voc_decision_seq

Overview:
Parametrised successor to the fixed five-input decision stage: it classifies N_CH unsigned sensor channels by sequential argmax-above-threshold. A consecutive-run stability filter sits on top, and the block gives a start/busy/valid handshake plus a change pulse. The pulse triggers a display update only when the committed class changes. It sits between the sensor front end and the display driver, in the slow clock domain.

Parameters:
N_CH, 5, number of sensor channels (2..15)
DATA_W, 32, width of each channel sample and of the threshold
CLASS_W, 4, width of class output; must satisfy 2**CLASS_W > N_CH
STABLE_CNT, 3, consecutive identical raw results needed to commit a class (1..15)

Ports:
clk  input  1  single clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request one classification; sampled only in IDLE
threshold  input  DATA_W  minimum sample value for a channel to be a candidate; captured at start
chan_data  input  N_CH*DATA_W  flattened samples, channel k at bits [k*DATA_W +: DATA_W]; captured at start
busy  output  1  high from the cycle after start is accepted through the DONE cycle
valid  output  1  one-cycle pulse when raw_class/class_out are updated
raw_class  output  CLASS_W  result of the latest run: 0 = none above threshold, k+1 = channel k
class_out  output  CLASS_W  committed (filtered) class
changed  output  1  one-cycle pulse, coincident with valid, when class_out takes a new value

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; busy, valid, changed = 0; raw_class, class_out = 0; run counter = 0; capture registers cleared. Reset mid-run aborts the run and emits no valid.
- States:
  - IDLE: on start=1, capture chan_data and threshold into registers. Clear best_idx=0 and best_val=0. Set ch=0 and go to SCAN.
  - SCAN: one channel per cycle. Channel ch is a candidate if sample >= threshold and (best_idx==0 or sample > best_val). A candidate sets best_idx=ch+1 and best_val=sample. When ch==N_CH-1, go to DONE; otherwise ch++.
  - DONE: run the stability filter (below), drive valid=1 for exactly this cycle, then return to IDLE.
- Ties: strict greater-than, so the lowest channel index wins among equal maxima.
- A threshold of 0 makes every channel a candidate.
- All comparisons are unsigned, DATA_W bits; no arithmetic overflow is possible.
- Latency: start sampled at edge T; busy=1 from T+1; valid=1 during cycle T+N_CH+1; busy falls with valid, at T+N_CH+2.
- start while busy is ignored, with no queuing. start held high re-triggers immediately on the cycle after DONE, i.e. back-to-back runs with one IDLE cycle.
- Input changes after capture do not affect the run in progress.
- Stability filter, evaluated in DONE:
  - raw_class <= best_idx.
  - If best_idx equals the previous raw_class and run_cnt < STABLE_CNT, run_cnt++; otherwise run_cnt=1.
  - Commit when the updated run_cnt reaches STABLE_CNT and best_idx differs from class_out: class_out <= best_idx and changed=1.
  - The counter saturates at STABLE_CNT, so a held class does not re-pulse changed.
  - STABLE_CNT=1 means every differing raw result commits immediately.
- The first run after reset compares against raw_class=0, so a result of 0 counts as a continuation.
- Outputs are registered; none are combinational from inputs.

Decomposition:
- Shared package voc_pkg: state enum (IDLE, SCAN, DONE), CLASS_NONE=0, and a function giving the required CLASS_W for a channel count, used by a parameter-legality assertion.
- One natural sub-module: class_stability_filter (inputs: raw class, update strobe; outputs: committed class, changed). It is instantiated once and keeps the filter separately testable.
- The scan datapath stays in the top module.

Test Plan:
- Basic argmax: N_CH=5, STABLE_CNT=1, threshold=100, chans={50,300,120,299,10}, start pulse -> busy for 6 cycles, valid at T+6, raw_class=2, class_out=2, changed=1.
- None above threshold: threshold=1000, all chans <1000 -> raw_class=0; class_out stays 0 and changed=0 from reset.
- Tie and equality: threshold=200, chans={200,500,500,7,500} -> raw_class=2 (lowest index); threshold=500, chans all 500 -> raw_class=1.
- Stability: STABLE_CNT=3, results 4,4,2,4,4,4,4 across runs -> class_out commits 4 only on the 6th valid with changed=1; the 7th valid gives changed=0.
- Handshake: start held high continuously -> valid every N_CH+2 cycles. A start pulse during SCAN and a chan_data change mid-scan -> no effect on the result.
- Reset mid-run: assert rst during SCAN cycle 2 -> next cycle busy=0, no valid; outputs 0; a following run behaves as after power-up.
